// File: rtl/kianv_clint.sv
// Core-local interruptor: msip/mtimecmp/mtime MMIO registers, prescaled timebase,
// and the machine software (IRQ3) and timer (IRQ7) interrupt lines.
module kianv_clint #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned TIMEBASE_HZ = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [15:0] addr,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        IRQ3,
    output logic        IRQ7,
    output logic [63:0] mtime
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / TIMEBASE_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [13:0] W_MSIP    = 14'h0000;
    localparam logic [13:0] W_CMP_LO  = 14'h1000;
    localparam logic [13:0] W_CMP_HI  = 14'h1001;
    localparam logic [13:0] W_TIME_LO = 14'h2FFE;
    localparam logic [13:0] W_TIME_HI = 14'h2FFF;

    generate
        if (DIV < 1 || (CLK_FREQ_HZ % TIMEBASE_HZ) != 0) begin : g_bad_div
            $error("kianv_clint: CLK_FREQ_HZ must be an integer multiple (>=1) of TIMEBASE_HZ");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic               accept_c;
    logic [PRE_W-1:0]   pre;
    logic               tick_c;
    logic [63:0]        mtimecmp;
    logic [13:0]        word_c;
    logic [31:0]        rd_c;
    logic               we_c;
    logic               unused_addr_lsb;

    // Address bits [1:0] carry no meaning in a word-aligned map.
    assign unused_addr_lsb = ^addr[1:0];
    assign word_c = addr[15:2];
    assign we_c   = accept_c && (wmask != 4'b0000);
    assign tick_c = (pre == PRE_W'(DIV - 1));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = m[i] ? din[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Bus FSM: accept in IDLE, respond for one cycle in RESP.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            IDLE: if (valid) begin
                accept_c  = 1'b1;
                state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        rd_c = 32'd0;
        case (word_c)
            W_MSIP:    rd_c = {31'd0, IRQ3};
            W_CMP_LO:  rd_c = mtimecmp[31:0];
            W_CMP_HI:  rd_c = mtimecmp[63:32];
            W_TIME_LO: rd_c = mtime[31:0];
            W_TIME_HI: rd_c = mtime[63:32];
            default:   rd_c = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready    <= 1'b0;
            rdata    <= 32'd0;
            IRQ3     <= 1'b0;
            IRQ7     <= 1'b0;
            mtimecmp <= '1;
            mtime    <= 64'd0;
            pre      <= '0;
        end else begin
            ready <= accept_c;
            rdata <= accept_c ? rd_c : 32'd0;
            pre   <= tick_c ? '0 : pre + PRE_W'(1);
            IRQ7  <= (mtime >= mtimecmp);

            if (we_c && word_c == W_MSIP && wmask[0]) IRQ3 <= wdata[0];
            if (we_c && word_c == W_CMP_LO) mtimecmp[31:0]  <= merge(mtimecmp[31:0], wdata, wmask);
            if (we_c && word_c == W_CMP_HI) mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata, wmask);

            // A bus write to either mtime half suppresses that cycle's increment entirely.
            if (we_c && word_c == W_TIME_LO)      mtime[31:0]  <= merge(mtime[31:0], wdata, wmask);
            else if (we_c && word_c == W_TIME_HI) mtime[63:32] <= merge(mtime[63:32], wdata, wmask);
            else if (tick_c)                      mtime        <= mtime + 64'd1;
        end
    end

endmodule

// File: tb/tb_kianv_clint.sv
// Directed bench for kianv_clint with DIV=5 (50 MHz clock, 10 MHz timebase).
module tb_kianv_clint;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [15:0] addr = 16'd0;
    logic [3:0]  wmask = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        IRQ3;
    logic        IRQ7;
    logic [63:0] mtime;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] rd;
    logic        irq3_at_ready;
    logic        irq7_at_ready;
    logic [63:0] mtime_at_ready;

    kianv_clint #(
        .CLK_FREQ_HZ(50_000_000),
        .TIMEBASE_HZ(10_000_000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .ready (ready),
        .addr  (addr),
        .wmask (wmask),
        .wdata (wdata),
        .rdata (rdata),
        .IRQ3  (IRQ3),
        .IRQ7  (IRQ7),
        .mtime (mtime)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus access; returns after the FSM is back in IDLE.
    task automatic bus(input logic [15:0] a, input logic [3:0] m, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        n = 0;
        addr = a; wmask = m; wdata = d; valid = 1'b1;
        step();
        while (!ready && n < 4) begin
            step();
            n++;
        end
        chk("ready_pulse", 64'(ready), 64'd1);
        r              = rdata;
        irq3_at_ready  = IRQ3;
        irq7_at_ready  = IRQ7;
        mtime_at_ready = mtime;
        valid = 1'b0; wmask = 4'd0;
        step();
        chk("ready_drop", 64'(ready), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] v;

        // Reset
        repeat (3) step();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_irq3", 64'(IRQ3), 64'd0);
        chk("rst_irq7", 64'(IRQ7), 64'd0);
        chk("rst_mtime", mtime, 64'd0);
        reset = 1'b0;

        // Timebase: first increment on the 5th edge, then every 5 edges
        repeat (4) step();
        chk("tb_e4", mtime, 64'd0);
        step();
        chk("tb_e5", mtime, 64'd1);
        repeat (4) step();
        chk("tb_e9", mtime, 64'd1);
        step();
        chk("tb_e10", mtime, 64'd2);
        repeat (90) step();
        chk("tb_e100", mtime, 64'd20);

        // Readback after reset
        bus(16'hBFF8, 4'b0000, 32'd0, rd);
        chk("rd_mtime_lo", 64'(rd), 64'd20);
        bus(16'h4000, 4'b0000, 32'd0, rd);
        chk("rd_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
        bus(16'h4004, 4'b0000, 32'd0, rd);
        chk("rd_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
        bus(16'h0000, 4'b0000, 32'd0, rd);
        chk("rd_msip", 64'(rd), 64'd0);
        bus(16'h2000, 4'b0000, 32'd0, rd);
        chk("rd_unmapped", 64'(rd), 64'd0);
        bus(16'h2000, 4'b1111, 32'hDEAD_BEEF, rd);
        bus(16'h2000, 4'b0000, 32'd0, rd);
        chk("rd_unmapped_after_wr", 64'(rd), 64'd0);
        chk("irq3_idle", 64'(IRQ3), 64'd0);
        chk("irq7_idle", 64'(IRQ7), 64'd0);

        // Back-to-back valid: ready alternates
        addr = 16'h0000; wmask = 4'd0; valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("hs_ready", 64'(ready), (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        valid = 1'b0;

        // Software interrupt and write masking
        bus(16'h0000, 4'b0001, 32'd1, rd);
        chk("msip_set_at_ready", 64'(irq3_at_ready), 64'd1);
        chk("msip_set", 64'(IRQ3), 64'd1);
        bus(16'h0000, 4'b0000, 32'd0, rd);
        chk("msip_read", 64'(rd), 64'd1);
        chk("msip_ro_hold", 64'(IRQ3), 64'd1);
        bus(16'h0000, 4'b0001, 32'd0, rd);
        chk("msip_clr", 64'(IRQ3), 64'd0);
        bus(16'h0000, 4'b1110, 32'hFFFF_FFFF, rd);
        chk("msip_mask_b0", 64'(IRQ3), 64'd0);
        bus(16'h0000, 4'b1111, 32'hFFFF_FFFF, rd);
        bus(16'h0000, 4'b0000, 32'd0, rd);
        chk("msip_upper_zero", 64'(rd), 64'd1);
        bus(16'h0000, 4'b0001, 32'd0, rd);

        // Timer interrupt rises the cycle after mtime reaches 30
        bus(16'h4004, 4'b1111, 32'd0, rd);
        bus(16'hBFF8, 4'b1111, 32'd0, rd);
        bus(16'h4000, 4'b1111, 32'd30, rd);
        chk("irq7_before", 64'(IRQ7), 64'd0);
        n = 0;
        while (mtime != 64'd30 && n < 300) begin
            step();
            n++;
        end
        chk("mtime_hit30", mtime, 64'd30);
        chk("irq7_at30", 64'(IRQ7), 64'd0);
        step();
        chk("irq7_rise", 64'(IRQ7), 64'd1);
        bus(16'h4000, 4'b1111, 32'hFFFF_FFFF, rd);
        chk("irq7_latency", 64'(irq7_at_ready), 64'd1);
        chk("irq7_fall", 64'(IRQ7), 64'd0);
        bus(16'h4004, 4'b1111, 32'hFFFF_FFFF, rd);
        chk("irq7_low", 64'(IRQ7), 64'd0);

        // Wrap from all-ones to zero
        bus(16'hBFFC, 4'b1111, 32'hFFFF_FFFF, rd);
        bus(16'hBFF8, 4'b1111, 32'hFFFF_FFFE, rd);
        n = 0;
        while (mtime != 64'hFFFF_FFFF_FFFF_FFFF && n < 12) begin
            step();
            n++;
        end
        chk("wrap_allones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_irq7_pre", 64'(IRQ7), 64'd0);
        step();
        chk("wrap_irq7_hi", 64'(IRQ7), 64'd1);
        n = 0;
        while (mtime == 64'hFFFF_FFFF_FFFF_FFFF && n < 12) begin
            step();
            n++;
        end
        chk("wrap_zero", mtime, 64'd0);
        chk("wrap_irq7_hold", 64'(IRQ7), 64'd1);
        step();
        chk("wrap_irq7_fall", 64'(IRQ7), 64'd0);

        // Write to mtime lo on a tick edge: no increment, no carry into hi
        v = mtime;
        n = 0;
        while (mtime == v && n < 12) begin
            step();
            n++;
        end
        bus(16'hBFF8, 4'b1111, 32'hFFFF_FFFF, rd);
        repeat (2) step();
        bus(16'hBFF8, 4'b1111, 32'h0000_0100, rd);
        chk("coll_old_lo", 64'(rd), 64'hFFFF_FFFF);
        chk("coll_mtime", mtime_at_ready, 64'h0000_0000_0000_0100);
        chk("coll_mtime_next", mtime, 64'h0000_0000_0000_0100);

        // Byte-masked write to mtimecmp lo
        bus(16'h4000, 4'b0010, 32'h1234_AB56, rd);
        bus(16'h4000, 4'b0000, 32'd0, rd);
        chk("cmp_bytemask", 64'(rd), 64'hFFFF_ABFF);

        // Reset during RESP drops the response and the committed write
        addr = 16'h0000; wmask = 4'b0001; wdata = 32'd1; valid = 1'b1;
        step();
        chk("rr_ready", 64'(ready), 64'd1);
        reset = 1'b1; valid = 1'b0; wmask = 4'd0;
        step();
        chk("rr_ready_drop", 64'(ready), 64'd0);
        chk("rr_rdata", 64'(rdata), 64'd0);
        chk("rr_irq3", 64'(IRQ3), 64'd0);
        reset = 1'b0;
        step();
        chk("rr_mtime", mtime, 64'd0);
        bus(16'h4000, 4'b0000, 32'd0, rd);
        chk("rr_cmp_lo", 64'(rd), 64'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
